// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the sequential RV32M multiply/divide unit: funct3 op codes,
// FSM states and the operand-signedness helpers used at request accept.
package alu_muldiv_seq_pkg;

  localparam logic [2:0] kMD_OP_MUL    = 3'd0;
  localparam logic [2:0] kMD_OP_MULH   = 3'd1;
  localparam logic [2:0] kMD_OP_MULHSU = 3'd2;
  localparam logic [2:0] kMD_OP_MULHU  = 3'd3;
  localparam logic [2:0] kMD_OP_DIV    = 3'd4;
  localparam logic [2:0] kMD_OP_DIVU   = 3'd5;
  localparam logic [2:0] kMD_OP_REM    = 3'd6;
  localparam logic [2:0] kMD_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    kMD_ST_IDLE  = 2'd0,
    kMD_ST_CALC  = 2'd1,
    kMD_ST_FIXUP = 2'd2,
    kMD_ST_DONE  = 2'd3
  } md_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == kMD_OP_MULH) || (op == kMD_OP_MULHSU) ||
           (op == kMD_OP_DIV)  || (op == kMD_OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == kMD_OP_MULH) || (op == kMD_OP_DIV) || (op == kMD_OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_divstep.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module md_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic            bit_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  // The partial remainder stays below the divisor, so XLEN+2 bits never wrap.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, div_i};
    q_o     = ~trial[XLEN+1];
    rem_o   = q_o ? trial[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fixup and valid/ready handshakes.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] kMostNeg = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     step_rem;
  logic              q_bit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign ready_o  = rst_ni && (state_q == kMD_ST_IDLE);
  assign valid_o  = rst_ni && (state_q == kMD_ST_DONE);
  assign result_o = valid_o ? result_q : '0;
  assign accept   = valid_i && ready_o;

  // For the multiply the low half of prod_q holds the multiplier and opb_q the
  // multiplicand; for the divide they hold the dividend/quotient and the divisor.
  md_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_i (rem_q),
    .div_i (opb_q),
    .bit_i (prod_q[XLEN-1]),
    .rem_o (step_rem),
    .q_o   (q_bit)
  );

  always_comb begin
    sa       = op_a_signed(op_i) && a_i[XLEN-1];
    sb       = op_b_signed(op_i) && b_i[XLEN-1];
    a_mag    = sa ? -a_i : a_i;
    b_mag    = sb ? -b_i : b_i;
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      kMD_ST_IDLE: begin
        if (accept) begin
          op_d    = op_i;
          cnt_d   = CW'(XLEN - 1);
          opb_d   = b_mag;
          prod_d  = {{XLEN{1'b0}}, a_mag};
          rem_d   = '0;
          neg_d   = (op_i[2] && op_i[1]) ? sa : (sa ^ sb);
          state_d = kMD_ST_CALC;
          if (op_i[2] && (b_i == '0)) begin
            result_d = op_i[1] ? a_i : '1;
            state_d  = kMD_ST_DONE;
          end else if (op_i[2] && !op_i[0] && (a_i == kMostNeg) && (b_i == '1)) begin
            result_d = op_i[1] ? '0 : a_i;
            state_d  = kMD_ST_DONE;
          end
        end
      end
      kMD_ST_CALC: begin
        if (op_q[2]) begin
          prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], q_bit};
          rem_d  = step_rem;
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = kMD_ST_FIXUP;
      end
      kMD_ST_FIXUP: begin
        case (op_q)
          kMD_OP_MUL:                            result_d = prod_fix[XLEN-1:0];
          kMD_OP_MULH, kMD_OP_MULHSU, kMD_OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          kMD_OP_DIV, kMD_OP_DIVU:               result_d = quo_fix;
          kMD_OP_REM, kMD_OP_REMU:               result_d = rem_fix;
          default:                               result_d = result_q;
        endcase
        state_d = kMD_ST_DONE;
      end
      kMD_ST_DONE: begin
        if (ready_i) state_d = kMD_ST_IDLE;
      end
      default: state_d = kMD_ST_IDLE;
    endcase
    // A flush kills any in-flight op and also drops a request arriving with it.
    if (flush_i) state_d = kMD_ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= kMD_ST_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Sequential RV32M multiply/divide unit: a parametrised companion to the single-cycle ALU in the execute stage. It performs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, one bit per clock, over a generic XLEN. Operands and results move through valid/ready handshakes, so the pipeline can stall on it. It also supports a flush for branch-mispredict kill.

## Interface
Parameters:
- XLEN, 32, operand/result width; any even value ≥ 8.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  abort any in-flight operation; has priority over everything except reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; high only in IDLE.
- op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- valid_o  out  1  result valid; high only in DONE.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result; 0 outside DONE.

## Operation
- States:
  - IDLE: ready_o=1, valid_o=0.
  - CALC: iterate.
  - FIXUP: apply sign, select half/quotient/remainder.
  - DONE: valid_o=1.
- Accept: valid_i & ready_o at a rising edge. Capture op, operand magnitudes and a negate flag; load counter = XLEN-1; go to CALC.
- Signedness:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - MUL uses the low XLEN bits, independent of sign.
  - Quotient negate = sign(a)^sign(b).
  - Remainder sign follows the dividend.
- Multiply: 2·XLEN product register, shift-add, one multiplier bit per CALC cycle. MUL returns the low half; MULH* return the high half of the signed-corrected product.
- Divide: restoring, one quotient bit per CALC cycle, with a (XLEN+1)-bit partial remainder.
- Counter reaches 0 in CALC → FIXUP → DONE.
- Fast paths are decided at accept and go straight to DONE:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → a_i.
  - Signed overflow (a = most negative, b = -1): DIV → a_i; REM → 0.
- DONE: result_o and valid_o are held stable until ready_i is sampled high, then the unit returns to IDLE. No accept is possible in the same cycle (ready_o=0 in DONE).
- flush_i from any state: next state IDLE, result discarded. If flush_i and an accept coincide in IDLE, the request is dropped.
- Reset:
  - State is IDLE and all datapath registers are 0.
  - While rst_ni is low: ready_o=0, valid_o=0, result_o=0.
  - Reset mid-operation abandons the operation.

## Timing
- Counting the accept cycle as 0:
  - Iterative ops assert valid_o in cycle XLEN+2 (34 for XLEN=32).
  - Fast paths assert valid_o in cycle 1.
- Latency is data-independent apart from the fast paths; there is no early-out on zero multiplier.
- Throughput: one op per XLEN+3 cycles with ready_i tied high.
- result_o and valid_o are registered (derived from state/registers only); there is no combinational path from a_i/b_i to outputs.
- ready_o is combinational from state and rst_ni only, never from valid_i.

## Structure
- Add to the shared defines header:
  - op encodings `kMD_OP_MUL … `kMD_OP_REMU;
  - state encodings `kMD_ST_IDLE/CALC/FIXUP/DONE.
- Sub-module md_divstep: one combinational restoring-divide step. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder, quotient bit.
- Top-level holds the FSM, counter, operand/product registers and sign fixup. Target ~250 lines.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) → 0xFFFFFFEB; valid_o rises exactly in cycle 34 after accept; ready_o low for cycles 1–34.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
  - REMU 100/7 → 2.
- Corner cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5, both with valid_o in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Backpressure: ready_i low for 5 cycles in DONE → result_o and valid_o held constant; ready_o stays 0; IDLE on the cycle after ready_i=1.
- Abort:
  - flush_i in cycle 10 of CALC → IDLE next cycle, valid_o never asserts, a following MULHU completes correctly.
  - Repeat with rst_ni low instead of flush_i → all outputs 0 during reset.
